// File: rtl/rtype_inst_encoder.sv
// rtype_inst_encoder: assembles {ALUSel, rd, rs1, rs2} requests into RV32I
// R-type words and streams them to instruction memory at incrementing,
// word-aligned addresses during a start-opened load session.
// Optional feature macro: RTYPE_ENC_REJECT_EN (drop ALUSel 1010..1111 and flag err).
module rtype_inst_encoder #(
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alusel,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [16:0]       count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [16:0] LAST_IDX  = 17'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state, state_next;
  logic        xfer;
  logic        write;
  logic        at_depth;
  logic        close;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] word;
`ifdef RTYPE_ENC_REJECT_EN
  logic        illegal;
`endif

  assign in_ready = (state == LOAD);

  // ALUSel to {funct7, funct3} and R-type word assembly
  always_comb begin
    funct7 = 7'h00;
    funct3 = 3'b000;
    case (in_alusel)
      4'b0000: funct3 = 3'b111;
      4'b0001: funct3 = 3'b110;
      4'b0010: funct3 = 3'b000;
      4'b0011: funct3 = 3'b100;
      4'b0100: funct3 = 3'b001;
      4'b0101: funct3 = 3'b101;
      4'b0110: begin funct7 = 7'h20; funct3 = 3'b000; end
      4'b0111: funct3 = 3'b010;
      4'b1000: begin funct7 = 7'h20; funct3 = 3'b101; end
      4'b1001: funct3 = 3'b011;
      default: begin funct7 = 7'h00; funct3 = 3'b000; end
    endcase
    word = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_RTYPE};
  end

  // Handshake qualification and next-state selection
  always_comb begin
    state_next = state;
    xfer       = in_valid && (state == LOAD);
`ifdef RTYPE_ENC_REJECT_EN
    illegal    = (in_alusel > 4'd9);
    write      = xfer && !illegal;
`else
    write      = xfer;
`endif
    at_depth   = write && (count == LAST_IDX);
    close      = xfer && (in_last || at_depth);
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (close) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Write port, session counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= BASE;
      wr_data <= '0;
      count   <= '0;
      done    <= 1'b0;
      full    <= 1'b0;
    end else begin
      wr_en <= write;
      done  <= close;
      if (write) begin
        wr_data <= word;
        wr_addr <= BASE + (ADDR_W'(count) << 2);
        count   <= count + 17'd1;
      end
      if (at_depth) full <= 1'b1;
      if ((state == IDLE) && start) begin
        count <= '0;
        full  <= 1'b0;
      end
    end
  end

`ifdef RTYPE_ENC_REJECT_EN
  // Sticky illegal-op flag, cleared when a new session opens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if ((state == IDLE) && start)   err <= 1'b0;
    else if (xfer && illegal)            err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtype_inst_encoder.sv
// tb_rtype_inst_encoder: directed and randomized checks of rtype_inst_encoder
// against a transaction-level reference model (DEPTH=4, BASE=0).
module tb_rtype_inst_encoder;

  localparam int unsigned TB_DEPTH = 4;
  localparam logic [31:0] TB_BASE  = 32'h0;
`ifdef RTYPE_ENC_REJECT_EN
  localparam bit REJECT = 1'b1;
`else
  localparam bit REJECT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alusel;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_last;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [16:0] count;
  logic        done, full, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_load, m_full, m_err, m_wr_en, m_done;
  int          m_count;
  logic [31:0] m_addr, m_data;

  always #5 clk = ~clk;

  rtype_inst_encoder #(
    .ADDR_W (32),
    .BASE   (TB_BASE),
    .DEPTH  (TB_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_alusel (in_alusel),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .done      (done),
    .full      (full),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // funct7/funct3 per ALUSel from the operation table; codes above 9 act as ADD
  function automatic logic [9:0] op_fields(input int op);
    case (op)
      0: return {7'h00, 3'b111};  // AND
      1: return {7'h00, 3'b110};  // OR
      2: return {7'h00, 3'b000};  // ADD
      3: return {7'h00, 3'b100};  // XOR
      4: return {7'h00, 3'b001};  // SLL
      5: return {7'h00, 3'b101};  // SRL
      6: return {7'h20, 3'b000};  // SUB
      7: return {7'h00, 3'b010};  // SLT
      8: return {7'h20, 3'b101};  // SRA
      9: return {7'h00, 3'b011};  // SLTU
      default: return {7'h00, 3'b000};
    endcase
  endfunction

  function automatic logic [31:0] enc(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    logic [9:0] f;
    f = op_fields(op);
    return {f[9:3], rs2, rs1, f[2:0], rd, 7'b0110011};
  endfunction

  // Controller-style decode: find the ALUSel whose fields match; 15 if none
  function automatic int dec(input logic [31:0] w);
    logic [9:0] f;
    if (w[6:0] != 7'b0110011) return 15;
    for (int i = 0; i < 10; i++) begin
      f = op_fields(i);
      if (w[31:25] == f[9:3] && w[14:12] == f[2:0]) return i;
    end
    return 15;
  endfunction

  task automatic model_reset();
    m_load = 0; m_full = 0; m_err = 0; m_wr_en = 0; m_done = 0;
    m_count = 0; m_addr = TB_BASE; m_data = '0;
  endtask

  task automatic set_req(input bit v, input int op, input int rd, input int rs1, input int rs2,
                         input bit last);
    in_valid  = v;
    in_alusel = 4'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_last   = last;
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(m_load));
    check("wr_en",    64'(wr_en),    64'(m_wr_en));
    check("done",     64'(done),     64'(m_done));
    check("count",    64'(count),    64'(m_count));
    check("full",     64'(full),     64'(m_full));
    check("err",      64'(err),      64'(m_err));
    check("wr_addr",  64'(wr_addr),  64'(m_addr));
    check("wr_data",  64'(wr_data),  64'(m_data));
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge
  task automatic step();
    bit close;
    m_wr_en = 0;
    m_done  = 0;
    if (!m_load) begin
      if (start) begin
        m_load = 1; m_count = 0; m_full = 0; m_err = 0;
      end
    end else if (in_valid) begin
      close = in_last;
      if (REJECT && in_alusel > 4'd9) begin
        m_err = 1;
      end else begin
        m_wr_en = 1;
        m_data  = enc(int'(in_alusel), in_rd, in_rs1, in_rs2);
        m_addr  = TB_BASE + 32'(4 * m_count);
        m_count++;
        if (m_count == TB_DEPTH) begin
          m_full = 1;
          close  = 1;
        end
      end
      if (close) begin
        m_load = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic open_session();
    set_req(0, 0, 0, 0, 0, 0);
    start = 1;
    step();
    start = 0;
  endtask

  task automatic close_session();
    if (m_load) begin
      set_req(1, 2, 0, 0, 0, 1);
      step();
    end
    set_req(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    start = 0;
    set_req(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1;
    step();

    // T1: single ADD with in_last
    open_session();
    set_req(1, 2, 3, 1, 2, 1);
    step();
    check("t1_data", 64'(wr_data), 64'h002081B3);
    check("t1_done", 64'(done), 64'h1);
    set_req(0, 0, 0, 0, 0, 0);
    step();

    // T2: back-to-back SUB then SRA
    open_session();
    set_req(1, 6, 5, 6, 7, 0);
    step();
    check("t2_sub", 64'(wr_data), 64'h407302B3);
    set_req(1, 8, 1, 2, 3, 1);
    step();
    check("t2_sra", 64'(wr_data), 64'h403150B3);
    check("t2_addr", 64'(wr_addr), 64'h4);
    set_req(0, 0, 0, 0, 0, 0);
    step();

    // T3: six requests without in_last, session closes full after DEPTH
    open_session();
    for (int i = 0; i < 6; i++) begin
      set_req(1, i % 10, i + 1, i + 2, i + 3, 0);
      step();
      if (i == 3) begin
        check("t3_full", 64'(full), 64'h1);
        check("t3_addr", 64'(wr_addr), 64'hC);
      end
    end
    check("t3_ready", 64'(in_ready), 64'h0);
    set_req(0, 0, 0, 0, 0, 0);

    // T4: out-of-range ALUSel held valid
    open_session();
    set_req(1, 15, 0, 0, 0, 0);
    step();
    if (REJECT) begin
      check("t4_err", 64'(err), 64'h1);
      check("t4_count", 64'(count), 64'h0);
    end else begin
      check("t4_data", 64'(wr_data), 64'h00000033);
    end
    step();
    close_session();
    step();

    // T5: asynchronous reset mid-session with a pending write
    open_session();
    set_req(1, 3, 4, 5, 6, 0);
    step();
    step();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1;
    set_req(0, 0, 0, 0, 0, 0);
    step();
    open_session();
    set_req(1, 1, 9, 10, 11, 1);
    step();
    check("t5_addr", 64'(wr_addr), 64'h0);
    set_req(0, 0, 0, 0, 0, 0);

    // T6: every ALUSel with x31 operands, decoded back
    for (int op = 0; op < 10; op++) begin
      open_session();
      set_req(1, op, 31, 31, 31, 1);
      step();
      check("t6_decode", 64'(dec(wr_data)), 64'(op));
      set_req(0, 0, 0, 0, 0, 0);
    end

    // Randomized traffic including start during LOAD and start alongside done
    for (int c = 0; c < 800; c++) begin
      start = ($urandom_range(0, 3) == 0);
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7) == 0);
      step();
    end
    start = 0;
    close_session();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
